// File: rtl/gfx_mem_arbiter.sv
// Pixel-memory arbiter: engine + display requests onto one frame-buffer RAM.
// Display has priority; a starvation limiter guarantees engine progress.
module gfx_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [DATA_W-1:0]   eng_data,
    input  logic [ADDR_W-1:0]   eng_addr,
    input  logic [DATA_W/8-1:0] eng_wben,
    input  logic                eng_op,
    input  logic                eng_rts,
    output logic                eng_rtr,
    input  logic [ADDR_W-1:0]   disp_addr,
    input  logic                disp_rts,
    output logic                disp_rtr,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   out_bcast_data,
    output logic                out_xfc_eng,
    output logic                out_xfc_disp
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       starved;
    logic       eng_go;
    logic       disp_go;

    // tag = {valid, is_read, src}; src 1 = engine, 0 = display
    logic       tag1_valid;
    logic       tag1_read;
    logic       tag1_src;
    logic       tag2_valid;
    logic       tag2_read;
    logic       tag2_src;

    assign starved = (starve_cnt == LIMIT);
    assign eng_go  = eng_rts && eng_rtr;
    assign disp_go = disp_rts && disp_rtr;

    // Grant: display first unless the engine has waited out the limit
    always_comb begin
        eng_rtr  = 1'b0;
        disp_rtr = 1'b0;
        if (rst_) begin
            if (disp_rts && !(eng_rts && starved)) begin
                disp_rtr = 1'b1;
            end else if (eng_rts) begin
                eng_rtr = 1'b1;
            end
        end
    end

    // Count display grants taken while the engine is waiting
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            starve_cnt <= '0;
        end else if (!eng_rts || eng_go) begin
            starve_cnt <= '0;
        end else if (disp_go && !starved) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Issue stage: register the granted request onto the RAM port
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (eng_go) begin
            mem_en   <= 1'b1;
            mem_addr <= eng_addr;
            if (eng_op) begin
                mem_we    <= eng_wben;
                mem_wdata <= eng_data;
            end else begin
                mem_we <= '0;
            end
        end else if (disp_go) begin
            mem_en   <= 1'b1;
            mem_we   <= '0;
            mem_addr <= disp_addr;
        end else begin
            mem_en <= 1'b0;
            mem_we <= '0;
        end
    end

    // Tag pipeline travelling alongside the issue and the RAM latency
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tag1_valid <= 1'b0;
            tag1_read  <= 1'b0;
            tag1_src   <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_read  <= 1'b0;
            tag2_src   <= 1'b0;
        end else begin
            tag1_valid <= eng_go || disp_go;
            tag1_read  <= eng_go ? !eng_op : disp_go;
            tag1_src   <= eng_go;
            tag2_valid <= tag1_valid;
            tag2_read  <= tag1_read;
            tag2_src   <= tag1_src;
        end
    end

    // Return stage: capture read data and strobe its owner
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_bcast_data <= '0;
            out_xfc_eng    <= 1'b0;
            out_xfc_disp   <= 1'b0;
        end else begin
            out_xfc_eng  <= tag2_valid && tag2_read && tag2_src;
            out_xfc_disp <= tag2_valid && tag2_read && !tag2_src;
            if (tag2_valid && tag2_read) begin
                out_bcast_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Scoreboard bench for gfx_mem_arbiter.
// Driver tasks push expected returns; a negedge monitor pops and compares.
module tb_gfx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_;
    logic [31:0] eng_data;
    logic [15:0] eng_addr;
    logic [3:0]  eng_wben;
    logic        eng_op;
    logic        eng_rts;
    logic        eng_rtr;
    logic [15:0] disp_addr;
    logic        disp_rts;
    logic        disp_rtr;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] out_bcast_data;
    logic        out_xfc_eng;
    logic        out_xfc_disp;

    typedef struct packed {
        logic        src;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    bit          glog[$];
    int          checks = 0;
    int          failures = 0;
    int          run = 0;
    int          max_run = 0;

    logic [31:0] ram [0:65535];
    bit          seen [0:65535];

    always #5 clk = ~clk;

    gfx_mem_arbiter dut (
        .clk            (clk),
        .rst_           (rst_),
        .eng_data       (eng_data),
        .eng_addr       (eng_addr),
        .eng_wben       (eng_wben),
        .eng_op         (eng_op),
        .eng_rts        (eng_rts),
        .eng_rtr        (eng_rtr),
        .disp_addr      (disp_addr),
        .disp_rts       (disp_rts),
        .disp_rtr       (disp_rtr),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .out_bcast_data (out_bcast_data),
        .out_xfc_eng    (out_xfc_eng),
        .out_xfc_disp   (out_xfc_disp)
    );

    function automatic logic [31:0] pat(input logic [15:0] a);
        return 32'hA500_0000 | {16'h0, a};
    endfunction

    // Frame-buffer RAM model; unwritten words read as a known pattern
    always @(posedge clk) begin
        logic [31:0] cur;
        if (mem_en) begin
            cur = seen[mem_addr] ? ram[mem_addr] : pat(mem_addr);
            mem_rdata <= cur;
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            ram[mem_addr] <= cur;
            seen[mem_addr] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on every transfer-complete strobe
    always @(negedge clk) begin
        exp_t e;
        if (eng_rts && disp_rts)
            check("one_grant", 32'(eng_rtr && disp_rtr), 32'h0);
        if (out_xfc_eng || out_xfc_disp) begin
            check("xfc_exclusive", 32'(out_xfc_eng && out_xfc_disp), 32'h0);
            if (sb.size() == 0) begin
                check("unexpected_xfc", 32'(out_xfc_eng), 32'h0);
                check("unexpected_xfc", 32'(out_xfc_disp), 32'h0);
            end else begin
                e = sb.pop_front();
                check("xfc_src", 32'(out_xfc_eng), 32'(e.src));
                check("bcast_data", out_bcast_data, e.data);
            end
        end
        if (out_xfc_disp) run++;
        else run = 0;
        if (run > max_run) max_run = run;
    end

    // Present one engine request and hold it until it transfers
    task automatic eng_req(input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input logic [31:0] exp);
        int n = 0;
        eng_op = wr;
        eng_addr = a;
        eng_data = d;
        eng_wben = be;
        eng_rts = 1'b1;
        #1;
        while (!eng_rtr) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL eng_timeout: eng_rtr=0 after %0d cycles, required 1", n);
                eng_rts = 1'b0;
                return;
            end
        end
        glog.push_back(1'b1);
        if (!wr) sb.push_back('{src: 1'b1, data: exp});
        @(negedge clk);
    endtask

    // Present one display read and hold it until it transfers
    task automatic disp_req(input logic [15:0] a, input logic [31:0] exp);
        int n = 0;
        disp_addr = a;
        disp_rts = 1'b1;
        #1;
        while (!disp_rtr) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL disp_timeout: disp_rtr=0 after %0d cycles, required 1", n);
                disp_rts = 1'b0;
                return;
            end
        end
        glog.push_back(1'b0);
        sb.push_back('{src: 1'b0, data: exp});
        @(negedge clk);
    endtask

    function automatic logic [31:0] pack_glog();
        logic [31:0] v = '0;
        for (int i = 0; i < glog.size() && i < 32; i++) v[i] = glog[i];
        return v;
    endfunction

    initial begin
        rst_ = 1'b0;
        eng_data = '0;
        eng_addr = '0;
        eng_wben = '0;
        eng_op = 1'b0;
        eng_rts = 1'b0;
        disp_addr = '0;
        disp_rts = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_bcast", out_bcast_data, 32'h0);
        check("rst_xfc", 32'({out_xfc_eng, out_xfc_disp}), 32'h0);

        // Both requesters rise together straight out of reset
        rst_ = 1'b1;
        eng_op = 1'b1;
        eng_addr = 16'h0000;
        eng_data = 32'h000F_0000;
        eng_wben = 4'hF;
        eng_rts = 1'b1;
        disp_addr = 16'h0400;
        disp_rts = 1'b1;
        #1;
        check("first_disp_rtr", 32'(disp_rtr), 32'h1);
        check("first_eng_rtr", 32'(eng_rtr), 32'h0);
        glog.delete();
        fork
            begin
                disp_req(16'h0400, pat(16'h0400));
                disp_req(16'h0401, pat(16'h0401));
                disp_rts = 1'b0;
            end
            begin
                eng_req(1'b1, 16'h0000, 32'h000F_0000, 4'hF, 32'h0);
                eng_rts = 1'b0;
            end
        join
        check("first_grant_cnt", 32'(glog.size()), 32'd3);
        check("first_grant_seq", pack_glog(), 32'h4);
        disp_req(16'h0000, 32'h000F_0000);
        disp_rts = 1'b0;

        // Engine write then read, with exact return latency
        eng_req(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
        eng_req(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
        eng_rts = 1'b0;
        #1;
        check("lat_e0_xfc", 32'(out_xfc_eng), 32'h0);
        @(negedge clk);
        #1;
        check("lat_e1_xfc", 32'(out_xfc_eng), 32'h0);
        @(negedge clk);
        #1;
        check("lat_e2_xfc_eng", 32'(out_xfc_eng), 32'h1);
        check("lat_e2_xfc_disp", 32'(out_xfc_disp), 32'h0);

        // Byte-lane merge
        @(negedge clk);
        eng_req(1'b1, 16'h0020, 32'h1122_3344, 4'hF, 32'h0);
        eng_req(1'b1, 16'h0020, 32'hAABB_CCDD, 4'h5, 32'h0);
        eng_req(1'b0, 16'h0020, 32'h0, 4'h0, 32'h11BB_33DD);
        // Write with no lanes enabled leaves memory alone
        eng_req(1'b1, 16'h0010, 32'hFFFF_FFFF, 4'h0, 32'h0);
        eng_req(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
        eng_rts = 1'b0;
        repeat (6) @(negedge clk);

        // Streaming display reads
        max_run = 0;
        for (int i = 0; i < 16; i++) disp_req(16'h0100 + 16'(i), pat(16'h0100 + 16'(i)));
        disp_rts = 1'b0;
        repeat (8) @(negedge clk);
        check("stream_run", 32'(max_run), 32'd16);
        check("bcast_hold", out_bcast_data, 32'hA500_010F);

        // Starvation limiter with both ports saturated
        glog.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) disp_req(16'h0200 + 16'(i), pat(16'h0200 + 16'(i)));
                disp_rts = 1'b0;
            end
            begin
                eng_req(1'b0, 16'h0300, 32'h0, 4'h0, pat(16'h0300));
                eng_req(1'b0, 16'h0301, 32'h0, 4'h0, pat(16'h0301));
                eng_rts = 1'b0;
            end
        join
        check("starve_grant_cnt", 32'(glog.size()), 32'd18);
        check("starve_grant_seq", pack_glog(), 32'h0002_0100);
        repeat (6) @(negedge clk);

        // Reset one cycle after a read transfer
        eng_op = 1'b0;
        eng_addr = 16'h0010;
        eng_rts = 1'b1;
        #1;
        check("rf_rtr", 32'(eng_rtr), 32'h1);
        @(posedge clk);
        @(negedge clk);
        eng_rts = 1'b0;
        @(posedge clk);
        #1;
        rst_ = 1'b0;
        #1;
        check("rf_mem_en", 32'(mem_en), 32'h0);
        check("rf_mem_addr", 32'(mem_addr), 32'h0);
        check("rf_mem_wdata", mem_wdata, 32'h0);
        check("rf_bcast", out_bcast_data, 32'h0);
        check("rf_xfc", 32'({out_xfc_eng, out_xfc_disp}), 32'h0);
        eng_rts = 1'b1;
        disp_rts = 1'b1;
        #1;
        check("rf_rtr_in_reset", 32'({eng_rtr, disp_rtr}), 32'h0);
        repeat (2) @(negedge clk);
        eng_rts = 1'b0;
        disp_rts = 1'b0;
        rst_ = 1'b1;
        repeat (6) @(negedge clk);
        eng_req(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
        eng_rts = 1'b0;

        repeat (8) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
